// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: fetches over a req/ack handshake,
// hands the word to decode, then picks sequential / branch / jump next PC.
module pc_sequencer #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter int               OFF_W        = 13
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   insn,
  output logic              insn_valid,
  input  logic              ex_done,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  input  logic [OFF_W-1:0]  label,
  input  logic              stall,
  output logic [XLEN-1:0]   pc,
  output logic              misalign
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, TRAP} state_t;

  state_t                  state;
  logic signed [XLEN-1:0]  offset;
  logic [XLEN-1:0]         target;

  function automatic logic signed [XLEN-1:0] sext(input logic [OFF_W-1:0] off);
    return {{(XLEN-OFF_W){off[OFF_W-1]}}, off};
  endfunction

  assign imem_addr = pc;
  assign offset    = sext(label);

  // Taken control transfers share one adder path; wrap-around is intentional.
  always_comb begin
    target = pc + XLEN'(4);
    if (jump || (branch && zero)) begin
      target = pc + offset;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      insn       <= '0;
      imem_req   <= 1'b0;
      insn_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      insn_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            insn       <= imem_rdata;
            imem_req   <= 1'b0;
            insn_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= EXEC;
        end
        EXEC: begin
          if (ex_done) begin
            // A misaligned target is never committed to pc.
            if (target[1:0] != 2'b00) begin
              misalign <= 1'b1;
              state    <= TRAP;
            end else begin
              pc <= target;
              if (!stall) begin
                state    <= FETCH;
                imem_req <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        TRAP: begin
          imem_req <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected (pc, insn) per fetch,
// a negedge monitor pops and compares on every insn_valid pulse.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] insn;
  logic        insn_valid;
  logic        ex_done;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [12:0] label;
  logic        stall;
  logic [31:0] pc;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_insn_q[$];

  localparam logic [31:0] MEM_KEY = 32'h1357_9BDF;

  pc_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .insn(insn), .insn_valid(insn_valid),
    .ex_done(ex_done), .branch(branch), .jump(jump), .zero(zero), .label(label),
    .stall(stall), .pc(pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the address.
  assign imem_rdata = imem_addr ^ MEM_KEY;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_insn(input logic [31:0] p);
    exp_pc_q.push_back(p);
    exp_insn_q.push_back(p ^ MEM_KEY);
  endtask

  always @(negedge clk) begin
    if (rst && insn_valid) begin
      if (exp_pc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_insn_valid: got pc %h want none", pc);
      end else begin
        chk("issue_pc", pc, exp_pc_q.pop_front());
        chk("issue_insn", insn, exp_insn_q.pop_front());
      end
    end
  end

  // Enter at a negedge; complete one fetch with wait_ack stall cycles; leave at EXEC.
  task automatic do_fetch(input int wait_ack, input logic [31:0] exp_addr);
    int n;
    expect_insn(exp_addr);
    imem_ack = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("fetch_req_timeout", {31'd0, imem_req}, 32'd1);
      return;
    end
    ex_done = (wait_ack > 0);
    for (int i = 0; i < wait_ack; i++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, exp_addr);
      chk("wait_no_valid", {31'd0, insn_valid}, 32'd0);
      @(negedge clk);
    end
    chk("fetch_addr", imem_addr, exp_addr);
    imem_ack = 1'b1;
    ex_done  = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
  endtask

  // Enter at a negedge while DUT is in EXEC; resolve one instruction.
  task automatic do_exec(input logic j, input logic b, input logic z, input logic [12:0] lab,
                         input logic stl, input logic [31:0] exp_next);
    jump = j; branch = b; zero = z; label = lab; stall = stl; ex_done = 1'b1;
    @(negedge clk);
    ex_done = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0; label = '0;
    chk("next_pc", pc, exp_next);
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b0; ex_done = 1'b0; branch = 1'b0; jump = 1'b0;
    zero = 1'b0; label = '0; stall = 1'b0;

    // Reset, then a free-running sequential stream with ack/ex_done tied high
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_insn", insn, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, insn_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    for (int p = 0; p < 4; p++) expect_insn(32'(p * 4));
    rst = 1'b1; imem_ack = 1'b1; ex_done = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("seq_valid", {31'd0, insn_valid}, {31'd0, (k % 3) == 1});
      if (k % 3 == 0) chk("seq_addr", imem_addr, 32'(4 * (k / 3)));
    end
    imem_ack = 1'b0; ex_done = 1'b0;

    // Branch taken / not taken, jump backward, jump priority
    do_exec(1'b1, 1'b0, 1'b0, 13'h1FFC, 1'b0, 32'd8);
    do_fetch(0, 32'd8);
    do_exec(1'b0, 1'b1, 1'b1, 13'd196, 1'b0, 32'd204);
    do_fetch(0, 32'd204);
    do_exec(1'b0, 1'b1, 1'b0, 13'd800, 1'b0, 32'd208);
    do_fetch(0, 32'd208);
    do_exec(1'b1, 1'b0, 1'b0, 13'd48, 1'b0, 32'h100);
    do_fetch(0, 32'h100);
    do_exec(1'b1, 1'b0, 1'b0, 13'h1F00, 1'b0, 32'h0);
    do_fetch(0, 32'h0);
    do_exec(1'b1, 1'b1, 1'b0, 13'd8, 1'b0, 32'd8);

    // Delayed ack, then stall at EXEC completion
    do_fetch(3, 32'd8);
    do_exec(1'b0, 1'b0, 1'b0, 13'd0, 1'b1, 32'd12);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc", pc, 32'd12);
      @(negedge clk);
    end
    stall = 1'b0;
    do_fetch(0, 32'd12);

    // Wrap-around past the top of the address space
    do_exec(1'b1, 1'b0, 1'b0, 13'h1FF0, 1'b0, 32'hFFFF_FFFC);
    do_fetch(0, 32'hFFFF_FFFC);
    do_exec(1'b0, 1'b0, 1'b0, 13'd0, 1'b0, 32'h0);
    chk("wrap_misalign", {31'd0, misalign}, 32'd0);
    do_fetch(0, 32'h0);
    do_exec(1'b1, 1'b0, 1'b0, 13'h040, 1'b0, 32'h40);

    // Reset while a fetch is pending, followed by a late ack
    chk("pend_req", {31'd0, imem_req}, 32'd1);
    chk("pend_addr", imem_addr, 32'h40);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    rst = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_insn", insn, 32'h0);
    chk("late_ack_valid", {31'd0, insn_valid}, 32'd0);
    chk("idle_to_fetch_req", {31'd0, imem_req}, 32'd1);

    // Misaligned jump traps until reset
    do_fetch(0, 32'h0);
    do_exec(1'b1, 1'b0, 1'b0, 13'd6, 1'b0, 32'h0);
    imem_ack = 1'b1; ex_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("trap_misalign", {31'd0, misalign}, 32'd1);
      chk("trap_req", {31'd0, imem_req}, 32'd0);
      chk("trap_pc", pc, 32'h0);
      chk("trap_valid", {31'd0, insn_valid}, 32'd0);
      @(negedge clk);
    end
    imem_ack = 1'b0; ex_done = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("trap_rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_pc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle controller that owns the program counter and sequences instruction fetch.
- Issues fetch requests to instruction memory using a req/ack handshake and hands each fetched instruction to decode.
- Waits for the execute stage to resolve, then selects the next PC: sequential, taken branch or jump.
- Sits between the instruction memory and the decode/execute datapath, replacing a free-running PC update.

Parameters:
XLEN, 32, PC and instruction width
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
OFF_W, 13, width of the signed byte offset `label` (RISC-V B/J-style immediate)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
imem_req  output  1  fetch request; held high until acknowledged
imem_addr  output  XLEN  fetch address; always equals pc
imem_ack  input  1  memory has valid data on imem_rdata this cycle
imem_rdata  input  XLEN  fetched instruction word
insn  output  XLEN  latched instruction presented to decode
insn_valid  output  1  one-cycle pulse: insn is new
ex_done  input  1  execute stage has resolved branch, jump and zero this cycle
branch  input  1  current instruction is a conditional branch
jump  input  1  current instruction is an unconditional jump
zero  input  1  ALU zero flag (branch condition)
label  input  OFF_W  signed byte offset relative to the current pc
stall  input  1  hold off new fetches
pc  output  XLEN  current program counter
misalign  output  1  sticky misaligned-target error

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE, pc=RESET_VECTOR, insn=0.
  - imem_req=0, insn_valid=0, misalign=0.
  - Reset has priority over every other input in every state.
- States: IDLE, FETCH, ISSUE, EXEC, TRAP.
- IDLE:
  - imem_req=0.
  - Moves to FETCH when stall==0; otherwise stays in IDLE.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable while imem_ack==0. stall is ignored once FETCH is entered.
  - When imem_ack==1: insn<=imem_rdata, go to ISSUE. imem_req falls to 0 in the next cycle.
- ISSUE:
  - insn_valid=1 for exactly this cycle.
  - Always moves to EXEC.
- EXEC:
  - Waits for ex_done. branch, jump, zero and label are sampled only in the cycle where ex_done==1.
  - Target selection, in priority order:
    - jump==1 -> pc + sext(label)
    - branch==1 and zero==1 -> pc + sext(label)
    - otherwise -> pc + 4
  - sext extends the OFF_W-bit label to XLEN bits, giving a range of -4096..+4095.
  - Addition is modulo 2^XLEN (wrap-around, no flag).
  - If target[1:0]!=0: go to TRAP, set misalign=1, leave pc unchanged.
  - Otherwise pc<=target, then go to FETCH if stall==0, else IDLE.
- TRAP:
  - imem_req=0, insn_valid=0, misalign held at 1.
  - Only reset leaves TRAP.
- Latency: minimum 3 cycles per instruction (FETCH with immediate ack, ISSUE, EXEC with immediate ex_done); each imem_ack or ex_done wait cycle adds one.
- imem_ack outside FETCH is ignored. This covers an ack arriving late after reset.
- ex_done outside EXEC is ignored.
- Reset mid-operation drops imem_req in the next cycle, with no completion of the pending fetch.
- insn holds its value until the next accepted fetch.

Test Plan:
1. Reset then sequential run:
   - Stimulus: rst=0 for 2 cycles, then rst=1; stall=0; imem_ack and ex_done tied high; branch=jump=0.
   - Required: imem_addr steps 0, 4, 8, 12; insn_valid pulses every 3rd cycle; insn matches imem_rdata.
2. Branch taken and not taken:
   - Stimulus A: at pc=8, branch=1, zero=1, label=196.
   - Required A: next pc=204.
   - Stimulus B: then branch=1, zero=0, label=800.
   - Required B: next pc=208.
3. Jump backward and priority:
   - Stimulus A: at pc=0x100, jump=1, label=13'h1F00 (-256).
   - Required A: next pc=0x000.
   - Stimulus B: jump=1, branch=1, zero=0, label=8.
   - Required B: pc+8 (jump wins).
4. Wait states and stall:
   - Stimulus: imem_ack delayed 3 cycles.
   - Required: imem_req=1 and imem_addr stable for 4 cycles; insn_valid only after ack.
   - Stimulus: stall=1 at EXEC completion.
   - Required: IDLE with imem_req=0 until stall=0.
5. Misalign and wrap:
   - Stimulus A: at pc=0, jump=1, label=6.
   - Required A: misalign=1, pc stays 0, imem_req=0 permanently; reset clears it.
   - Stimulus B: at pc=0xFFFF_FFFC, sequential step.
   - Required B: pc=0, misalign=0.
6. Reset mid-fetch:
   - Stimulus: rst=0 while FETCH is waiting at pc=0x40; imem_ack=1 in the cycle after reset.
   - Required: next cycle imem_req=0, pc=0, state IDLE; the late ack does not update insn.
